// File: rtl/n13_frame_loader.sv
// Deserialises a stream of AN codewords row-major into a 5x5 frame and holds the
// complete frame on a flat bus until the downstream decoder array accepts it.
//   state | meaning
//   FILL  | accepting codewords into slots, in_ready high
//   HOLD  | complete frame presented, input stalled until frame_ready
module n13_frame_loader #(
   parameter int CW_W  = 6,
   parameter int ROWS  = 5,
   parameter int COLS  = 5,
   parameter int CNT_W = 8,
   localparam int NSLOT = ROWS * COLS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sof,
   input  logic [CW_W-1:0]         in_cw,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic [NSLOT*CW_W-1:0]   frame_cw,
   output logic [4:0]              wr_idx,
   output logic                    sync_err,
   output logic [CNT_W-1:0]        frame_cnt
);

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [4:0] LAST_IDX = 5'(NSLOT - 1);

   state_t                  state_q, state_d;
   logic [4:0]              wr_idx_q, wr_idx_d;
   logic                    frame_valid_q, frame_valid_d;
   logic [NSLOT*CW_W-1:0]   frame_cw_q, frame_cw_d;
   logic                    sync_err_q, sync_err_d;
   logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;

   always_comb begin
      state_d       = state_q;
      wr_idx_d      = wr_idx_q;
      frame_valid_d = frame_valid_q;
      frame_cw_d    = frame_cw_q;
      sync_err_d    = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      case (state_q)
         FILL: begin
            if (in_valid) begin
               if (in_sof) begin
                  // A start marker always restarts the frame; mid-frame it flags misalignment.
                  frame_cw_d[0 +: CW_W] = in_cw;
                  wr_idx_d              = 5'd1;
                  sync_err_d            = (wr_idx_q != 5'd0);
               end else if (wr_idx_q == 5'd0) begin
                  sync_err_d = 1'b1;
               end else begin
                  for (int k = 1; k < NSLOT; k++) begin
                     if (wr_idx_q == 5'(k)) frame_cw_d[k*CW_W +: CW_W] = in_cw;
                  end
                  if (wr_idx_q == LAST_IDX) begin
                     wr_idx_d      = 5'd0;
                     state_d       = HOLD;
                     frame_valid_d = 1'b1;
                  end else begin
                     wr_idx_d = wr_idx_q + 5'd1;
                  end
               end
            end
         end
         HOLD: begin
            if (frame_ready) begin
               frame_valid_d = 1'b0;
               state_d       = FILL;
               frame_cnt_d   = frame_cnt_q + 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= FILL;
         wr_idx_q      <= 5'd0;
         frame_valid_q <= 1'b0;
         frame_cw_q    <= '0;
         sync_err_q    <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wr_idx_q      <= wr_idx_d;
         frame_valid_q <= frame_valid_d;
         frame_cw_q    <= frame_cw_d;
         sync_err_q    <= sync_err_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign in_ready    = (state_q == FILL);
   assign frame_valid = frame_valid_q;
   assign frame_cw    = frame_cw_q;
   assign wr_idx      = wr_idx_q;
   assign sync_err    = sync_err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_n13_frame_loader.sv
// Directed and randomized checks of n13_frame_loader against a slot-array reference model.
module tb_n13_frame_loader;

   localparam int CW_W  = 6;
   localparam int NSLOT = 25;
   localparam int FW    = NSLOT * CW_W;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            in_sof = 1'b0;
   logic [CW_W-1:0] in_cw = '0;
   logic            frame_valid;
   logic            frame_ready = 1'b0;
   logic [FW-1:0]   frame_cw;
   logic [4:0]      wr_idx;
   logic            sync_err;
   logic [7:0]      frame_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: frame as an array of slots plus a fill position
   logic [CW_W-1:0] m_slot [NSLOT];
   int              m_idx;
   bit              m_hold;
   bit              m_sync;
   int              m_cnt;

   always #5 clk = ~clk;

   n13_frame_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .in_cw(in_cw), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_cw(frame_cw), .wr_idx(wr_idx), .sync_err(sync_err), .frame_cnt(frame_cnt)
   );

   function automatic logic [FW-1:0] m_frame();
      logic [FW-1:0] f = '0;
      for (int k = 0; k < NSLOT; k++) f[k*CW_W +: CW_W] = m_slot[k];
      return f;
   endfunction

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("in_ready",    FW'(in_ready),    FW'(!m_hold));
      check("frame_valid", FW'(frame_valid), FW'(m_hold));
      check("wr_idx",      FW'(wr_idx),      FW'(m_idx));
      check("sync_err",    FW'(sync_err),    FW'(m_sync));
      check("frame_cnt",   FW'(frame_cnt),   FW'(m_cnt[7:0]));
      check("frame_cw",    frame_cw,         m_frame());
   endtask

   task automatic model_step(input bit v, input bit sof, input logic [CW_W-1:0] cw,
                             input bit fr, input bit r);
      if (r) begin
         m_hold = 0; m_idx = 0; m_sync = 0; m_cnt = 0;
         for (int k = 0; k < NSLOT; k++) m_slot[k] = '0;
         return;
      end
      m_sync = 0;
      if (m_hold) begin
         if (fr) begin
            m_hold = 0;
            m_cnt  = (m_cnt + 1) % 256;
         end
      end else if (v) begin
         if (sof) begin
            m_sync    = (m_idx != 0);
            m_slot[0] = cw;
            m_idx     = 1;
         end else if (m_idx == 0) begin
            m_sync = 1;
         end else begin
            m_slot[m_idx] = cw;
            if (m_idx == NSLOT - 1) begin
               m_idx  = 0;
               m_hold = 1;
            end else begin
               m_idx++;
            end
         end
      end
   endtask

   // one clock: drive at negedge, model at posedge, compare at next negedge
   task automatic cycle(input bit v, input bit sof, input logic [CW_W-1:0] cw,
                        input bit fr, input bit r, output bit took);
      in_valid = v; in_sof = sof; in_cw = cw; frame_ready = fr; rst = r;
      took = v && !m_hold && !r;
      @(posedge clk);
      model_step(v, sof, cw, fr, r);
      @(negedge clk);
      check_all();
   endtask

   task automatic send_frame(input logic [CW_W-1:0] base, input bit random_gaps,
                             input bit fr);
      bit took;
      int guard;
      for (int k = 0; k < NSLOT; k++) begin
         took  = 0;
         guard = 0;
         while (!took) begin
            bit v;
            v = random_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(v, k == 0, base + CW_W'(k), random_gaps ? ($urandom_range(0, 2) != 0) : fr,
                  1'b0, took);
            guard++;
            if (guard > 200) begin
               n_assert++; n_fail++;
               $error("FAIL beat_timeout observed=stalled expected=accepted");
               $fatal(1, "FAIL beat_timeout");
            end
         end
      end
   endtask

   initial begin
      bit         took;
      logic [FW-1:0] held;
      int         guard;

      // reset
      cycle(0, 0, '0, 0, 1, took);
      cycle(0, 0, '0, 0, 1, took);
      check("reset_ready", FW'(in_ready), FW'(1));

      // 1: basic frame, slot k = k
      send_frame(6'd0, 0, 1);
      check("t1_valid", FW'(frame_valid), FW'(1));
      check("t1_slot5", FW'(frame_cw[5*CW_W +: CW_W]), FW'(5));
      check("t1_slot24", FW'(frame_cw[24*CW_W +: CW_W]), FW'(24));
      cycle(0, 0, '0, 1, 0, took);
      check("t1_cnt", FW'(frame_cnt), FW'(1));

      // 2: hold with frame_ready low, beats offered but not consumed
      send_frame(6'd20, 0, 0);
      held = frame_cw;
      for (int i = 0; i < 10; i++) cycle(1, i[0], 6'h3F, 0, 0, took);
      check("t2_stable", frame_cw, held);
      check("t2_cnt", FW'(frame_cnt), FW'(1));
      cycle(0, 0, '0, 1, 0, took);

      // 3: leading non-sof word is dropped
      cycle(1, 0, 6'h2A, 0, 0, took);
      check("t3_sync", FW'(sync_err), FW'(1));
      cycle(0, 0, '0, 0, 0, took);
      check("t3_sync_one", FW'(sync_err), FW'(0));
      cycle(1, 1, 6'h11, 0, 0, took);
      check("t3_slot0", FW'(frame_cw[0 +: CW_W]), FW'(6'h11));

      // 4: sof reasserted at wr_idx 12
      for (int k = 1; k < 12; k++) cycle(1, 0, 6'(k), 0, 0, took);
      check("t4_idx12", FW'(wr_idx), FW'(12));
      cycle(1, 1, 6'h0D, 0, 0, took);
      check("t4_sync", FW'(sync_err), FW'(1));
      check("t4_slot0", FW'(frame_cw[0 +: CW_W]), FW'(6'h0D));
      check("t4_idx1", FW'(wr_idx), FW'(1));
      for (int k = 1; k < NSLOT; k++) cycle(1, 0, 6'(k + 30), 0, 0, took);
      check("t4_done", FW'(frame_valid), FW'(1));
      cycle(0, 0, '0, 1, 0, took);

      // 5: reset mid-fill and during hold
      for (int k = 0; k < 20; k++) cycle(1, k == 0, 6'(k + 7), 0, 0, took);
      cycle(1, 0, 6'h15, 1, 1, took);
      check("t5_fill_idx", FW'(wr_idx), FW'(0));
      check("t5_fill_cw", frame_cw, FW'(0));
      send_frame(6'd3, 0, 0);
      cycle(0, 0, '0, 1, 1, took);
      check("t5_hold_valid", FW'(frame_valid), FW'(0));
      check("t5_hold_cnt", FW'(frame_cnt), FW'(0));

      // 6: 256 frames with random gaps and backpressure
      for (int f = 0; f < 256; f++) begin
         send_frame(6'($urandom), 1, 0);
         guard = 0;
         while (m_hold) begin
            cycle($urandom_range(0, 1) == 1, 0, 6'($urandom), $urandom_range(0, 2) != 0, 0, took);
            guard++;
            if (guard > 100) begin
               n_assert++; n_fail++;
               $error("FAIL hold_timeout observed=held expected=released");
               $fatal(1, "FAIL hold_timeout");
            end
         end
      end
      check("t6_wrap", FW'(frame_cnt), FW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
